// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling FSM, single-entry
// output holding register with valid/ready handshake and error pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_sig,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W = (PULSE_WIDTH > 2) ? $clog2(PULSE_WIDTH) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic                  r_sync1, r_sync2;
  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_armed;

  logic w_rx_s, w_tick, w_done, w_ferr;

  assign w_rx_s = r_sync2;
  assign w_tick = (r_cnt == '0);
  assign w_done = (r_state == STOP) && w_tick && w_rx_s;
  assign w_ferr = (r_state == STOP) && w_tick && !w_rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_sig;
      r_sync2 <= r_sync1;
    end
  end

  // r_armed blocks a line that is still low after reset from posing as a
  // start edge; it sets on the first high sample and stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_armed <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rx_s) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= START;
            r_cnt   <= CNT_HALF;
          end
        end
        START: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (w_rx_s) begin
            r_state <= IDLE;
          end else begin
            r_state <= DATA;
            r_idx   <= '0;
            r_cnt   <= CNT_FULL;
          end
        end
        DATA: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_shift[r_idx] <= w_rx_s;
            r_cnt          <= CNT_FULL;
            if (r_idx == IDX_LAST) begin
              r_state <= STOP;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IDX_ONE;
            end
          end
        end
        STOP: begin
          if (!w_tick) r_cnt <= r_cnt - CNT_ONE;
          else         r_state <= w_rx_s ? IDLE : BREAK;
        end
        BREAK: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Holding register: a completing byte wins over a same-cycle consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_ferr;
      overrun   <= 1'b0;
      if (w_done) begin
        if (!valid || ready) begin
          data  <= r_shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a negedge monitor counts
// output activity and each scenario task checks its own expectations.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_sig = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int         mon_valid = 0;
  int         mon_ferr  = 0;
  int         mon_ovr   = 0;
  logic [7:0] mon_data  = 8'h00;

  uart_rx #(.DATA_WIDTH(8), .BAUD_RATE(100), .CLK_FREQ(1600)) dut (
    .clk(clk), .rst(rst), .rx_sig(rx_sig), .ready(ready),
    .data(data), .valid(valid), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      mon_valid = mon_valid + 1;
      mon_data  = data;
    end
    if (frame_err) mon_ferr = mon_ferr + 1;
    if (overrun)   mon_ovr  = mon_ovr + 1;
  end

  // Called on a negedge; line changes take effect from the next posedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
    rx_sig = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_sig = b[i];
      repeat (16) @(negedge clk);
    end
    rx_sig = stop_val;
    repeat (stop_len) @(negedge clk);
    rx_sig = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_sig = 1'b1; ready = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_basic;
    int v0, f0, o0;
    ready = 1'b1;
    v0 = mon_valid; f0 = mon_ferr; o0 = mon_ovr;
    send_frame(8'hA5, 1'b1, 16);
    repeat (10) @(negedge clk);
    n_checks++; if (mon_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", mon_data); end
    n_checks++; if (mon_valid - v0 != 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", mon_valid - v0); end
    n_checks++; if (mon_ferr - f0 != 0) begin n_fail++; $display("FAIL basic_ferr: got %0d want 0", mon_ferr - f0); end
    n_checks++; if (mon_ovr - o0 != 0) begin n_fail++; $display("FAIL basic_ovr: got %0d want 0", mon_ovr - o0); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_end: got %b want 0", valid); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    ready = 1'b1;
    v0 = mon_valid; f0 = mon_ferr;
    rx_sig = 1'b0;
    repeat (4) @(negedge clk);
    rx_sig = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++; if (mon_valid - v0 != 0) begin n_fail++; $display("FAIL glitch_valid: got %0d want 0", mon_valid - v0); end
    n_checks++; if (mon_ferr - f0 != 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d want 0", mon_ferr - f0); end
    send_frame(8'h5A, 1'b1, 16);
    repeat (10) @(negedge clk);
    n_checks++; if (mon_data !== 8'h5A) begin n_fail++; $display("FAIL glitch_next_data: got %h want 5a", mon_data); end
    n_checks++; if (mon_valid - v0 != 1) begin n_fail++; $display("FAIL glitch_next_valid: got %0d want 1", mon_valid - v0); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    ready = 1'b1;
    v0 = mon_valid; f0 = mon_ferr;
    send_frame(8'h3C, 1'b0, 40);
    repeat (30) @(negedge clk);
    n_checks++; if (mon_ferr - f0 != 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", mon_ferr - f0); end
    n_checks++; if (mon_valid - v0 != 0) begin n_fail++; $display("FAIL ferr_valid: got %0d want 0", mon_valid - v0); end
    send_frame(8'h81, 1'b1, 16);
    repeat (10) @(negedge clk);
    n_checks++; if (mon_data !== 8'h81) begin n_fail++; $display("FAIL ferr_next_data: got %h want 81", mon_data); end
    n_checks++; if (mon_valid - v0 != 1) begin n_fail++; $display("FAIL ferr_next_valid: got %0d want 1", mon_valid - v0); end
    n_checks++; if (mon_ferr - f0 != 1) begin n_fail++; $display("FAIL ferr_total: got %0d want 1", mon_ferr - f0); end
  endtask

  task automatic test_overrun;
    int o0;
    ready = 1'b0;
    o0 = mon_ovr;
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    repeat (10) @(negedge clk);
    n_checks++; if (data !== 8'h11) begin n_fail++; $display("FAIL ovr_data: got %h want 11", data); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", valid); end
    n_checks++; if (mon_ovr - o0 != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", mon_ovr - o0); end
    ready = 1'b1;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume: got %b want 0", valid); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int o0;
    ready = 1'b0;
    o0 = mon_ovr;
    send_frame(8'h55, 1'b1, 16);
    repeat (4) @(negedge clk);
    n_checks++; if (data !== 8'h55 || valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %h/%b want 55/1", data, valid); end
    // Stop bit of the next frame is sampled on the 155th posedge after launch.
    fork
      send_frame(8'h66, 1'b1, 16);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        n_checks++; if (data !== 8'h66) begin n_fail++; $display("FAIL b2b_data: got %h want 66", data); end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", valid); end
        @(negedge clk);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", valid); end
      end
    join
    repeat (4) @(negedge clk);
    n_checks++; if (mon_ovr - o0 != 0) begin n_fail++; $display("FAIL b2b_ovr: got %0d want 0", mon_ovr - o0); end
  endtask

  task automatic test_mid_reset;
    int v0, f0;
    ready = 1'b1;
    v0 = mon_valid; f0 = mon_ferr;
    fork
      send_frame(8'hF0, 1'b1, 16);
      begin
        repeat (70) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", data); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b want 0", overrun); end
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    send_frame(8'h0F, 1'b1, 16);
    repeat (10) @(negedge clk);
    n_checks++; if (mon_data !== 8'h0F) begin n_fail++; $display("FAIL rst_next_data: got %h want 0f", mon_data); end
    n_checks++; if (mon_valid - v0 != 1) begin n_fail++; $display("FAIL rst_next_valid: got %0d want 1", mon_valid - v0); end
    n_checks++; if (mon_ferr - f0 != 0) begin n_fail++; $display("FAIL rst_next_ferr: got %0d want 0", mon_ferr - f0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_back_to_back;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
